// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_pkg
//  Description : Shared MM:SS field width, default limits and timer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_pkg;

  localparam int FIELD_W     = 6;
  localparam int DEF_MAX_MIN = 59;
  localparam int DEF_MAX_SEC = 59;

  typedef logic [1:0] state_t;

  localparam state_t c_ST_IDLE    = 2'd0;
  localparam state_t c_ST_RUN     = 2'd1;
  localparam state_t c_ST_PAUSED  = 2'd2;
  localparam state_t c_ST_EXPIRED = 2'd3;

  typedef struct packed {
    logic [FIELD_W-1:0] mm;
    logic [FIELD_W-1:0] ss;
  } mmss_t;

  function automatic logic mmss_is_zero(input mmss_t v);
    return (v.mm == '0) && (v.ss == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk by TICK_DIV while enabled; one-cycle tick output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  // The count sits at zero when TICK_DIV is 1, so every enabled cycle ticks.
  assign tick = en & w_at_last;

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable MM:SS down-counter with pause/resume and sticky done.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
  import time_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int MAX_MIN  = DEF_MAX_MIN,
  parameter int MAX_SEC  = DEF_MAX_SEC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_min,
  input  logic [FIELD_W-1:0] load_sec,
  input  logic               start,
  input  logic               pause,
  input  logic               clr_done,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] sec,
  output logic               running,
  output logic               done,
  output logic               load_err
);

  localparam logic [FIELD_W-1:0] c_MAX_MIN = FIELD_W'(MAX_MIN);
  localparam logic [FIELD_W-1:0] c_MAX_SEC = FIELD_W'(MAX_SEC);

  state_t r_state;
  state_t w_state_nxt;
  mmss_t  r_val;
  logic   r_done;
  logic   r_load_err;

  logic   w_is_run;
  logic   w_load_req;
  logic   w_load_ok;
  logic   w_pause_ok;
  logic   w_start_ok;
  logic   w_tick;
  logic   w_expire;
  logic   w_clr_done;

  assign w_is_run   = (r_state == c_ST_RUN);

  // Any load outside RUN owns the cycle, whether it is accepted or rejected.
  assign w_load_req = load & ~w_is_run;
  assign w_load_ok  = w_load_req & (load_min <= c_MAX_MIN) & (load_sec <= c_MAX_SEC);

  assign w_pause_ok = pause & w_is_run;
  assign w_start_ok = start & ~pause & ~w_load_req & ~mmss_is_zero(r_val) &
                      ((r_state == c_ST_IDLE) | (r_state == c_ST_PAUSED));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_is_run & ~pause),
    .clr   (w_start_ok | w_load_ok),
    .tick  (w_tick)
  );

  // RUN never holds 00:00, so 00:01 is the only value that expires on a tick.
  assign w_expire   = w_tick & (r_val.mm == '0) & (r_val.ss == FIELD_W'(1));
  assign w_clr_done = w_load_ok | (clr_done & ~w_load_req);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load_ok) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_PAUSED: begin
          if (w_start_ok) begin
            w_state_nxt = c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (w_pause_ok) begin
            w_state_nxt = c_ST_PAUSED;
          end else if (w_expire) begin
            w_state_nxt = c_ST_EXPIRED;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    running  = w_is_run;
    min      = r_val.mm;
    sec      = r_val.ss;
    done     = r_done;
    load_err = r_load_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val <= '0;
    end else if (w_load_ok) begin
      r_val.mm <= load_min;
      r_val.ss <= load_sec;
    end else if (w_tick) begin
      if (r_val.ss != '0) begin
        r_val.ss <= r_val.ss - 1'b1;
      end else begin
        r_val.ss <= c_MAX_SEC;
        r_val.mm <= r_val.mm - 1'b1;
      end
    end
  end

  // Expiry takes precedence over a coincident clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else if (w_expire) begin
      r_done <= 1'b1;
    end else if (w_clr_done) begin
      r_done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_load_req & ~w_load_ok;
    end
  end

endmodule
`default_nettype wire
